regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32-entry x 32-bit register bank (built from 32-bit write-enabled registers) between N_REQ requesters, e.g. ALU writeback, load unit, link-register write and debug port.
- Arbitrates with a round-robin scheme, registers the winning write and drives a decoded one-hot write_enable vector straight into the bank's per-register write_enable inputs.
- Sits between the execute/writeback stages and the register bank.

---
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 tb/tb_regfile_write_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port.
// Registers the winning write and drives a one-hot per-register write enable.
module regfile_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1,
  parameter int IDX_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      freeze,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [(1<<ADDR_W)-1:0]    wr_enable_vec,
  output logic [IDX_W-1:0]          last_grant,
  output logic [15:0]               drop_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]  ptr;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              any_grant;
  logic              drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage 0: combinational round-robin scan starting just after ptr
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    gnt_idx   = '0;
    gnt_addr  = '0;
    gnt_data  = '0;
    any_grant = 1'b0;
    if (reset && !freeze) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (!any_grant && req_valid[idx]) begin
          any_grant  = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = IDX_W'(idx);
          gnt_addr   = req_addr[idx*ADDR_W +: ADDR_W];
          gnt_data   = req_data[idx*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign req_ready = grant;
  // Register-0 writes are still acknowledged but never reach the bank
  assign drop      = any_grant && (ZERO_REG != 0) && (gnt_addr == '0);

  // Stage 1: registered write to the bank
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr        <= PTR_RST;
      last_grant <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      drop_count <= '0;
    end else begin
      wr_valid <= any_grant && !drop;
      if (any_grant) begin
        ptr        <= gnt_idx;
        last_grant <= gnt_idx;
      end
      if (drop) begin
        drop_count <= sat_inc(drop_count);
      end else if (any_grant) begin
        wr_addr <= gnt_addr;
        wr_data <= gnt_data;
      end
    end
  end

  assign wr_enable_vec = wr_valid ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_addr) : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with the default
// configuration (4 requesters, 32 x 32-bit bank, register 0 hardwired zero).
module tb_regfile_write_arbiter;

  localparam int N_REQ = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int IDX_W = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    freeze;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    wr_valid;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [31:0]             wr_enable_vec;
  logic [IDX_W-1:0]        last_grant;
  logic [15:0]             drop_count;

  int vectors = 0;
  int errors  = 0;

  regfile_write_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(1), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_enable_vec(wr_enable_vec),
    .last_grant(last_grant), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; everything is sampled then too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    freeze = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    freeze = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    vectors++;
    if (wr_valid !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
      errors++; $display("FAIL reset_wr got v=%b a=%0d d=%h want 0/0/0", wr_valid, wr_addr, wr_data);
    end
    vectors++;
    if (drop_count !== 16'd0 || last_grant !== 2'd0) begin
      errors++; $display("FAIL reset_ctr got drop=%0d lg=%0d want 0/0", drop_count, last_grant);
    end
    req_valid = '0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    set_req(2, 5'd7, 32'hDEADBEEF);
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    vectors++;
    if (wr_valid !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_wr got v=%b a=%0d d=%h want 1/7/deadbeef", wr_valid, wr_addr, wr_data);
    end
    vectors++;
    if (wr_enable_vec !== 32'h0000_0080 || last_grant !== 2'd2) begin
      errors++; $display("FAIL single_en got en=%h lg=%0d want 00000080/2", wr_enable_vec, last_grant);
    end
    tick();
    vectors++;
    if (wr_valid !== 1'b0) begin errors++; $display("FAIL single_once got wr_valid=%b want 0", wr_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 5'(i + 8), 32'hA000_0000 + i);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL rr_ready cycle %0d got %b want %b", c, req_ready, 4'(1 << (c % 4)));
      end
      tick();
      vectors++;
      if (wr_valid !== 1'b1 || wr_addr !== 5'((c % 4) + 8) || wr_data !== 32'hA000_0000 + (c % 4)) begin
        errors++; $display("FAIL rr_wr cycle %0d got v=%b a=%0d d=%h want 1/%0d/%h",
                           c, wr_valid, wr_addr, wr_data, (c % 4) + 8, 32'hA000_0000 + (c % 4));
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_zero_reg();
    set_req(1, 5'd0, 32'h1234_5678);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_ack %0d got %b want 0010", c, req_ready); end
      tick();
      vectors++;
      if (wr_valid !== 1'b0 || wr_enable_vec !== 32'd0) begin
        errors++; $display("FAIL zero_wr %0d got v=%b en=%h want 0/0", c, wr_valid, wr_enable_vec);
      end
    end
    req_valid = '0;
    vectors++;
    if (drop_count !== 16'd3) begin errors++; $display("FAIL zero_count got %0d want 3", drop_count); end
    vectors++;
    if (wr_addr !== 5'd11 || wr_data !== 32'hA000_0003) begin
      errors++; $display("FAIL zero_hold got a=%0d d=%h want 11/a0000003", wr_addr, wr_data);
    end
    vectors++;
    if (last_grant !== 2'd1) begin errors++; $display("FAIL zero_ptr got %0d want 1", last_grant); end
  endtask

  task automatic test_freeze();
    do_reset();
    set_req(1, 5'd5, 32'h0000_0055);
    set_req(3, 5'd6, 32'h0000_0066);
    req_valid = 4'b1010;
    freeze = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL frz_ready %0d got %b want 0000", c, req_ready); end
      tick();
      vectors++;
      if (wr_valid !== 1'b0 || last_grant !== 2'd0) begin
        errors++; $display("FAIL frz_wr %0d got v=%b lg=%0d want 0/0", c, wr_valid, last_grant);
      end
    end
    freeze = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL frz_first got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b1000;
    vectors++;
    if (wr_valid !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h55) begin
      errors++; $display("FAIL frz_wr1 got v=%b a=%0d d=%h want 1/5/55", wr_valid, wr_addr, wr_data);
    end
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL frz_second got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    vectors++;
    if (wr_valid !== 1'b1 || wr_addr !== 5'd6 || last_grant !== 2'd3) begin
      errors++; $display("FAIL frz_wr2 got v=%b a=%0d lg=%0d want 1/6/3", wr_valid, wr_addr, last_grant);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 5'd4, 32'h0000_0444);
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant got %b want 0001", req_ready); end
    tick();
    vectors++;
    if (wr_valid !== 1'b1 || wr_addr !== 5'd4) begin
      errors++; $display("FAIL mid_wr got v=%b a=%0d want 1/4", wr_valid, wr_addr);
    end
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b want 0000", req_ready); end
    tick();
    vectors++;
    if (wr_valid !== 1'b0 || wr_addr !== 5'd0 || wr_enable_vec !== 32'd0) begin
      errors++; $display("FAIL mid_squash got v=%b a=%0d en=%h want 0/0/0", wr_valid, wr_addr, wr_enable_vec);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first got %b want 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_req(0, 5'd0, 32'hFFFF_FFFF);
    req_valid = 4'b0001;
    for (int c = 0; c < 65535; c++) tick();
    vectors++;
    if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", drop_count); end
    tick();
    vectors++;
    if (drop_count !== 16'hFFFF || wr_valid !== 1'b0) begin
      errors++; $display("FAIL sat_hold got drop=%h v=%b want ffff/0", drop_count, wr_valid);
    end
    req_valid = '0;
  endtask

  initial begin
    reset = 1'b0;
    freeze = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_reg();
    test_freeze();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
